// File: rtl/pitch_pkg.sv
// Shared constants, note-frequency table and state encoding for the pitch
// quantizer. Frequency words are in the same units as the synth pitch table.
package pitch_pkg;

  localparam int PITCH_COUNT = 48;
  localparam int PITCH_W     = 6;
  localparam int FREQ_W      = 24;
  localparam int ERR_W       = 25;

  localparam logic [FREQ_W-1:0] FREQ_TABLE [PITCH_COUNT] = '{
    24'd33488,  24'd35479,  24'd37589,  24'd39824,  24'd42192,  24'd44701,
    24'd47359,  24'd50175,  24'd53159,  24'd56320,  24'd59669,  24'd63217,
    24'd66976,  24'd70959,  24'd75178,  24'd79649,  24'd84385,  24'd89402,
    24'd94719,  24'd100351, 24'd106318, 24'd112640, 24'd119338, 24'd126434,
    24'd133952, 24'd141918, 24'd150356, 24'd159297, 24'd168769, 24'd178805,
    24'd189437, 24'd200702, 24'd212636, 24'd225280, 24'd238676, 24'd252868,
    24'd267905, 24'd283835, 24'd300713, 24'd318594, 24'd337539, 24'd357610,
    24'd378874, 24'd401403, 24'd425272, 24'd450560, 24'd477352, 24'd505737
  };

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_RD  = 3'd1,
    S_CMP = 3'd2,
    N_RD  = 3'd3,
    N_CMP = 3'd4,
    OUT   = 3'd5
  } state_e;

  function automatic logic [FREQ_W-1:0] note_freq(input logic [PITCH_W-1:0] p);
    logic [FREQ_W-1:0] f_s;
    if (p < 6'd48) begin
      f_s = FREQ_TABLE[p];
    end else begin
      f_s = 24'd0;
    end
    return f_s;
  endfunction

  // Midpoint between note p and p+1 (floored); above pitch 46 the search treats it as infinite.
  function automatic logic [FREQ_W-1:0] thresh(input logic [PITCH_W-1:0] p);
    logic [FREQ_W:0] sum_s;
    if (p < 6'd47) begin
      sum_s = {1'b0, FREQ_TABLE[p]} + {1'b0, FREQ_TABLE[p + 6'd1]};
    end else begin
      sum_s = 25'd0;
    end
    return sum_s[FREQ_W:1];
  endfunction

endpackage

// File: rtl/pitch_rom.sv
// Single-port synchronous ROM holding both the note frequencies and the
// decision thresholds between neighbouring notes.
module pitch_rom
  import pitch_pkg::*;
(
  input  logic               clk,
  input  logic [PITCH_W-1:0] addr,
  input  logic               sel_thresh,
  output logic [FREQ_W-1:0]  data
);

  logic [FREQ_W-1:0] data_r;

  // One-cycle read; sel_thresh picks the threshold view over the note view.
  always_ff @(posedge clk) begin
    if (sel_thresh) begin
      data_r <= thresh(addr);
    end else begin
      data_r <= note_freq(addr);
    end
  end

  assign data = data_r;

endmodule

// File: rtl/freq_to_pitch.sv
// Quantizes a frequency word to the nearest pitch index by a six-step binary
// search over the note thresholds, then reports the residual and range flags.
module freq_to_pitch
  import pitch_pkg::*;
#(
  parameter logic [FREQ_W-1:0] FREQ_LO = 24'd32535,
  parameter logic [FREQ_W-1:0] FREQ_HI = 24'd520556
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FREQ_W-1:0]  in_freq,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PITCH_W-1:0] out_pitch,
  output logic [ERR_W-1:0]   out_err,
  output logic               out_under,
  output logic               out_over
);

  state_e             state_r, state_s;
  logic [FREQ_W-1:0]  freq_r, freq_s;
  logic [PITCH_W-1:0] lo_r, lo_s, hi_r, hi_s;
  logic [2:0]         iter_r, iter_s;
  logic [PITCH_W:0]   sum_s;
  logic [PITCH_W-1:0] mid_s;
  logic [PITCH_W-1:0] rom_addr_s;
  logic               rom_sel_s;
  logic [FREQ_W-1:0]  rom_data_s;
  logic               valid_r, valid_s;
  logic [PITCH_W-1:0] pitch_r, pitch_s;
  logic [ERR_W-1:0]   err_r, err_s;
  logic               under_r, under_s;
  logic               over_r, over_s;

  pitch_rom u_rom (
    .clk        (clk),
    .addr       (rom_addr_s),
    .sel_thresh (rom_sel_s),
    .data       (rom_data_s)
  );

  assign sum_s    = {1'b0, lo_r} + {1'b0, hi_r};
  assign mid_s    = sum_s[PITCH_W:1];
  assign in_ready = (state_r == IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (in_valid) state_s = S_RD; else state_s = IDLE;
      S_RD:    state_s = S_CMP;
      S_CMP:   if (iter_r == 3'd5) state_s = N_RD; else state_s = S_RD;
      N_RD:    state_s = N_CMP;
      N_CMP:   state_s = OUT;
      OUT:     if (out_ready) state_s = IDLE; else state_s = OUT;
      default: state_s = IDLE;
    endcase
  end

  // ROM addressing, search bounds and next output values.
  always_comb begin
    freq_s     = freq_r;
    lo_s       = lo_r;
    hi_s       = hi_r;
    iter_s     = iter_r;
    rom_addr_s = mid_s;
    rom_sel_s  = 1'b1;
    valid_s    = valid_r;
    pitch_s    = pitch_r;
    err_s      = err_r;
    under_s    = under_r;
    over_s     = over_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          freq_s = in_freq;
          lo_s   = 6'd0;
          hi_s   = 6'd63;
          iter_s = 3'd0;
        end else begin
          freq_s = freq_r;
        end
      end
      S_RD: begin
        rom_addr_s = mid_s;
      end
      S_CMP: begin
        // Addresses at or above 47 behave as an infinite threshold.
        if ((mid_s >= 6'd47) || (freq_r < rom_data_s)) begin
          hi_s = mid_s;
        end else begin
          lo_s = mid_s + 6'd1;
        end
        iter_s = iter_r + 3'd1;
      end
      N_RD: begin
        rom_addr_s = lo_r;
        rom_sel_s  = 1'b0;
      end
      N_CMP: begin
        rom_addr_s = lo_r;
        rom_sel_s  = 1'b0;
        pitch_s    = lo_r;
        err_s      = {1'b0, freq_r} - {1'b0, rom_data_s};
        under_s    = (freq_r < FREQ_LO);
        over_s     = (freq_r > FREQ_HI);
        valid_s    = 1'b1;
      end
      OUT: begin
        if (out_ready) begin
          valid_s = 1'b0;
        end else begin
          valid_s = 1'b1;
        end
      end
      default: begin
        valid_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      freq_r  <= 24'd0;
      lo_r    <= 6'd0;
      hi_r    <= 6'd63;
      iter_r  <= 3'd0;
      valid_r <= 1'b0;
      pitch_r <= 6'd0;
      err_r   <= 25'd0;
      under_r <= 1'b0;
      over_r  <= 1'b0;
    end else begin
      freq_r  <= freq_s;
      lo_r    <= lo_s;
      hi_r    <= hi_s;
      iter_r  <= iter_s;
      valid_r <= valid_s;
      pitch_r <= pitch_s;
      err_r   <= err_s;
      under_r <= under_s;
      over_r  <= over_s;
    end
  end

  assign out_valid = valid_r;
  assign out_pitch = pitch_r;
  assign out_err   = err_r;
  assign out_under = under_r;
  assign out_over  = over_r;

endmodule

// File: tb/tb_freq_to_pitch.sv
// Scoreboard bench for freq_to_pitch: directed vectors plus a table sweep,
// with a monitor popping expected results whenever a result is handed over.
module tb_freq_to_pitch;

  typedef struct packed {
    logic [23:0] freq;
    logic [5:0]  pitch;
    logic [24:0] err;
    logic        under;
    logic        over;
  } exp_t;

  localparam int FT [48] = '{
    33488,  35479,  37589,  39824,  42192,  44701,  47359,  50175,
    53159,  56320,  59669,  63217,  66976,  70959,  75178,  79649,
    84385,  89402,  94719,  100351, 106318, 112640, 119338, 126434,
    133952, 141918, 150356, 159297, 168769, 178805, 189437, 200702,
    212636, 225280, 238676, 252868, 267905, 283835, 300713, 318594,
    337539, 357610, 378874, 401403, 425272, 450560, 477352, 505737
  };

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_freq;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_pitch;
  logic [24:0] out_err;
  logic        out_under;
  logic        out_over;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   rise_cyc = 0;
  logic prev_valid = 1'b0;

  freq_to_pitch dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_freq   (in_freq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pitch (out_pitch),
    .out_err   (out_err),
    .out_under (out_under),
    .out_over  (out_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int thr(input int i);
    return (FT[i] + FT[i+1]) / 2;
  endfunction

  // Reference: linear scan for the first threshold above the input.
  function automatic exp_t model(input logic [23:0] f);
    exp_t e;
    int   p;
    int   d;
    p = 47;
    for (int i = 46; i >= 0; i--) if (int'(f) < thr(i)) p = i;
    d       = int'(f) - FT[p];
    e.freq  = f;
    e.pitch = 6'(p);
    e.err   = 25'(d);
    e.under = (int'(f) < 32535);
    e.over  = (int'(f) > 520556);
    return e;
  endfunction

  function automatic exp_t mk(input int p, input int d, input bit u, input bit o);
    exp_t e;
    e.freq  = 24'd0;
    e.pitch = 6'(p);
    e.err   = 25'(d);
    e.under = u;
    e.over  = o;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic issue(input logic [23:0] f, input exp_t e, input bit push);
    int t;
    exp_t ee;
    ee      = e;
    ee.freq = f;
    if (push) exp_q.push_back(ee);
    in_freq  = f;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: freq=%0d never accepted", f);
      if (push) void'(exp_q.pop_back());
      in_valid = 1'b0;
    end else begin
      accept_cyc = cyc + 1;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic issue_m(input int f);
    issue(24'(f), model(24'(f)), 1'b1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every handed-over result must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = out_valid;
    if (!reset && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: pitch=%0d err=%0d", out_pitch, $signed(out_err));
      end else begin
        e = exp_q.pop_front();
        if (out_pitch !== e.pitch || out_err !== e.err ||
            out_under !== e.under || out_over !== e.over) begin
          n_fail++;
          $display("FAIL result freq=%0d: got pitch=%0d err=%0d u=%0b o=%0b, required pitch=%0d err=%0d u=%0b o=%0b",
                   e.freq, out_pitch, $signed(out_err), out_under, out_over,
                   e.pitch, $signed(e.err), e.under, e.over);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    int a2;
    int rel;
    int t;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_freq   = 24'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state", 64'({in_ready, out_valid, out_pitch, out_err, out_under, out_over}),
          64'({1'b1, 1'b0, 6'd0, 25'd0, 1'b0, 1'b0}));
    @(posedge clk);
    #1;

    // Exact note; the accepting edge is the first of the fifteen.
    issue(24'd56320, mk(9, 0, 1'b0, 1'b0), 1'b1);
    a1 = accept_cyc;
    t = 0;
    while (rise_cyc <= a1 && t < 40) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("latency", 64'(rise_cyc - a1 + 1), 64'd15);

    issue(24'd57993, mk(9, 1673, 1'b0, 1'b0), 1'b1);
    issue(24'd57994, mk(10, -1675, 1'b0, 1'b0), 1'b1);
    issue(24'd0, mk(0, -33488, 1'b1, 1'b0), 1'b1);
    issue(24'hFFFFFF, mk(47, 16271478, 1'b0, 1'b1), 1'b1);

    // Back-to-back requests with the consumer always ready.
    wait_drain();
    issue(24'd56320, mk(9, 0, 1'b0, 1'b0), 1'b1);
    a1 = accept_cyc;
    issue(24'd57994, mk(10, -1675, 1'b0, 1'b0), 1'b1);
    a2 = accept_cyc;
    check("spacing", 64'(a2 - a1), 64'd16);

    for (int p = 0; p < 48; p++) issue_m(FT[p]);
    for (int p = 0; p < 47; p++) begin
      issue_m(thr(p) - 1);
      issue_m(thr(p));
    end
    issue_m(32534);
    issue_m(32535);
    issue_m(520556);
    issue_m(520557);

    // Back-pressure: result held while a second request waits at the input.
    wait_drain();
    out_ready = 1'b0;
    issue(24'd100000, mk(19, -351, 1'b0, 1'b0), 1'b1);
    exp_q.push_back(mk(45, -10560, 1'b0, 1'b0));
    exp_q[exp_q.size()-1].freq = 24'd440000;
    in_freq  = 24'd440000;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    repeat (20) begin
      check("hold_stable", 64'({out_valid, in_ready, out_pitch, out_err, out_under, out_over}),
            64'({1'b1, 1'b0, 6'd19, 25'(-351), 1'b0, 1'b0}));
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    rel = cyc + 1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("accept_after_release", 64'(cyc + 1), 64'(rel + 1));
    @(posedge clk);
    #1 in_valid = 1'b0;

    // Reset in the seventh cycle of a search discards it.
    wait_drain();
    issue(24'd200000, mk(0, 0, 1'b0, 1'b0), 1'b0);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_reset", 64'({in_ready, out_valid, out_pitch, out_err, out_under, out_over}),
          64'({1'b1, 1'b0, 6'd0, 25'd0, 1'b0, 1'b0}));
    @(posedge clk);
    #1;
    issue(24'd300000, mk(38, -713, 1'b0, 1'b0), 1'b1);
    wait_drain();
    repeat (20) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
